// File: rtl/aes_subbytes_pkg.sv
// Shared definitions for the masked SubBytes controller: FSM encoding,
// byte width and share/byte index helpers.
package aes_subbytes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int BYTE_W = 8;

  // Counter width for an index range of n entries (at least one bit).
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // LSB position of share s, byte k inside a flat shared-state vector.
  function automatic int byte_lsb(input int s, input int k, input int nbytes);
    return BYTE_W * (nbytes * s + k);
  endfunction

endpackage

// File: rtl/aes_subbytes_ctrl_delay.sv
// valid_delay_line: LATENCY-deep tag shift register mirroring the S-box pipeline.
module valid_delay_line #(
  parameter int LATENCY = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic vld_i,
  output logic vld_o
);

  logic [LATENCY:1] vld_pipe;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_pipe <= '0;
    end else if (clr_i) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= vld_i;
      for (int i = 2; i <= LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign vld_o = vld_pipe[LATENCY];

endmodule

// File: rtl/aes_subbytes_ctrl.sv
// Streams a shared AES state byte-by-byte through an external pipelined S-box
// and reassembles the result. Build option: SUBBYTES_CLEAR_EN.
module aes_subbytes_ctrl
  import aes_subbytes_pkg::*;
#(
  parameter int SHARES  = 2,
  parameter int NBYTES  = 16,
  parameter int LATENCY = 4
) (
  input  logic                              ClkxCI,
  input  logic                              RstxBI,
  input  logic                              StartxSI,
  input  logic                              AbortxSI,
  input  logic [BYTE_W*NBYTES*SHARES-1:0]   StatexDI,
  output logic [BYTE_W*SHARES-1:0]          SboxInxDO,
  input  logic [BYTE_W*SHARES-1:0]          SboxOutxDI,
  output logic                              RandEnxSO,
  output logic [BYTE_W*NBYTES*SHARES-1:0]   StatexDO,
  output logic                              BusyxSO,
  output logic                              DonexSO
);

  localparam int            CW   = cnt_w(NBYTES);
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  state_e state_q, state_d;
  logic [CW-1:0] feed_cnt_q, col_cnt_q;
  logic [SHARES-1:0][NBYTES-1:0][BYTE_W-1:0] in_buf_q, out_buf_q;
  logic [SHARES-1:0][BYTE_W-1:0] fed_byte, sbox_res;
  logic load, feeding, tag_out;

  assign load     = (state_q == IDLE) && StartxSI && !AbortxSI;
  assign feeding  = (state_q == FEED);
  assign sbox_res = SboxOutxDI;

  for (genvar s = 0; s < SHARES; s++) begin : g_share
    assign fed_byte[s] = in_buf_q[s][feed_cnt_q];
  end

  valid_delay_line #(.LATENCY(LATENCY)) u_tags (
    .clk_i  (ClkxCI),
    .rst_ni (RstxBI),
    .clr_i  (AbortxSI),
    .vld_i  (feeding),
    .vld_o  (tag_out)
  );

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (load) state_d = FEED;
      FEED:  if (feed_cnt_q == LAST) state_d = DRAIN;
      DRAIN: if (tag_out && col_cnt_q == LAST) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (AbortxSI) state_d = IDLE;
  end

  assign RandEnxSO = feeding;
  assign BusyxSO   = (state_q == FEED) || (state_q == DRAIN);
  assign DonexSO   = (state_q == DONE);
  assign StatexDO  = out_buf_q;

  // Output buffer is deliberately not cleared on load: the previous result
  // stays readable until the new job overwrites it byte by byte.
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      feed_cnt_q <= '0;
      col_cnt_q  <= '0;
      in_buf_q   <= '0;
      out_buf_q  <= '0;
    end else if (AbortxSI) begin
      feed_cnt_q <= '0;
      col_cnt_q  <= '0;
    end else if (load) begin
      in_buf_q   <= StatexDI;
      feed_cnt_q <= '0;
      col_cnt_q  <= '0;
    end else begin
      if (feeding) begin
        if (feed_cnt_q != LAST) feed_cnt_q <= feed_cnt_q + CW'(1);
`ifdef SUBBYTES_CLEAR_EN
        for (int s = 0; s < SHARES; s++) in_buf_q[s][feed_cnt_q] <= '0;
`endif
      end
      if (tag_out) begin
        for (int s = 0; s < SHARES; s++) out_buf_q[s][col_cnt_q] <= sbox_res[s];
        if (col_cnt_q != LAST) col_cnt_q <= col_cnt_q + CW'(1);
      end
    end
  end

`ifdef SUBBYTES_CLEAR_EN
  assign SboxInxDO = feeding ? fed_byte : '0;
`else
  logic [SHARES-1:0][BYTE_W-1:0] last_q;

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI)      last_q <= '0;
    else if (feeding) last_q <= fed_byte;
  end

  assign SboxInxDO = feeding ? fed_byte : last_q;
`endif

endmodule

// File: doc/aes_subbytes_ctrl.md
AES_SUBBYTES_CTRL -- requirements
Module: aes_subbytes_ctrl

Interface
REQ-001 SHALL have parameter SHARES, default 2: number of Boolean shares per byte.
REQ-002 SHALL have parameter NBYTES, default 16: bytes per SubBytes job.
REQ-003 SHALL have parameter LATENCY, default 4: cycles from S-box input to S-box output; must equal the attached S-box pipeline depth.
REQ-004 SHALL have port ClkxCI, input, 1 bit: clock, all state updates on rising edge.
REQ-005 SHALL have port RstxBI, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port StartxSI, input, 1 bit: job request, sampled only in IDLE.
REQ-007 SHALL have port AbortxSI, input, 1 bit: synchronous job cancel.
REQ-008 SHALL have port StatexDI, input, 8*NBYTES*SHARES bits: shared state, share s byte k at [8*NBYTES*s + 8*k +: 8].
REQ-009 SHALL have port SboxInxDO, output, 8*SHARES bits: byte to S-box, share s at [8*s +: 8].
REQ-010 SHALL have port SboxOutxDI, input, 8*SHARES bits: S-box result, same share layout.
REQ-011 SHALL have port RandEnxSO, output, 1 bit: high when the S-box consumes a real byte this cycle; gates the fresh-randomness source.
REQ-012 SHALL have port StatexDO, output, 8*NBYTES*SHARES bits: substituted state, same layout as StatexDI.
REQ-013 SHALL have port BusyxSO, output, 1 bit: high in FEED and DRAIN.
REQ-014 SHALL have port DonexSO, output, 1 bit: one-cycle completion pulse.

Function
REQ-015 SHALL implement FSM states IDLE, FEED, DRAIN, DONE.
REQ-016 IDLE with StartxSI=1 SHALL load StatexDI into the input buffer, clear the feed and collect counters, and go to FEED.
REQ-017 FEED SHALL drive byte k on SboxInxDO with RandEnxSO=1 for cycles k=0..NBYTES-1 after the load edge, then go to DRAIN.
REQ-018 A valid-tag shift register LATENCY deep SHALL track fed bytes; when its tag emerges, SboxOutxDI SHALL be written to output byte index = collect counter, and the counter SHALL increment.
REQ-019 DRAIN SHALL hold RandEnxSO=0 and go to DONE on the edge that writes byte NBYTES-1.
REQ-020 DONE SHALL last exactly one cycle with DonexSO=1 and StatexDO valid, then go to IDLE; StatexDO SHALL hold until the next job's first write.
REQ-021 DonexSO SHALL assert exactly NBYTES+LATENCY cycles after the load edge.
REQ-022 StartxSI while not in IDLE SHALL be ignored; Start and Abort together in IDLE: Abort wins, no load.
REQ-023 AbortxSI in FEED/DRAIN/DONE SHALL return to IDLE next edge, clear valid tags and counters, and suppress DonexSO.
REQ-024 Counters SHALL be clog2(NBYTES) bits wide and never wrap within a job.

Reset
REQ-025 RstxBI=0 SHALL immediately force IDLE and zero all buffers, counters, tags, SboxInxDO, StatexDO, RandEnxSO, BusyxSO, and DonexSO, including mid-job.

Configuration
REQ-026 Macro SUBBYTES_CLEAR_EN defined: SboxInxDO SHALL be all-zero outside FEED, and each input-buffer byte SHALL be zeroed on the cycle it is fed; undefined: SboxInxDO holds the last fed byte and the input buffer retains the loaded state.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding and the byte/share index helper constants.
REQ-028 The valid-tag delay line SHALL be one sub-module, valid_delay_line, parameterised by LATENCY.

Verification
REQ-029 Start, all shares 0x00, real aes_sbox attached -> after 20 cycles DonexSO=1, every byte's share XOR = 0x63.
REQ-030 Unmasked byte 0 = 0x53 split as shares 0xA5/0xF6, other bytes 0x00 -> byte 0 XOR = 0xED, others 0x63.
REQ-031 Start pulsed again at cycles 3 and 10 of a job -> ignored, single DonexSO at cycle 20.
REQ-032 Abort at cycle 8 -> IDLE at cycle 9, no DonexSO, RandEnxSO=0; new Start then completes normally.
REQ-033 RstxBI low at cycle 12 -> all outputs 0 asynchronously, no DonexSO after release.
REQ-034 RandEnxSO high for exactly 16 consecutive cycles per job; with SUBBYTES_CLEAR_EN, SboxInxDO=0 whenever RandEnxSO=0.
